i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
- I2S serializer in the audio clock domain, driven by the 24.576 MHz audio PLL output.
- Accepts stereo PCM sample pairs from the core mixer through a valid/ready handshake.
- Generates BCLK, LRCK and SDATA toward the board DAC.
- With defaults: 24.576 MHz / 8 / 64 = 48 kHz frame rate.

Parameters:
- SAMPLE_W, 16: PCM bits per channel, two's complement, MSB first; 1..SLOT_W.
- SLOT_W, 32: BCLK periods per channel slot; frame = 2*SLOT_W bits.
- BCLK_DIV, 8: clk cycles per BCLK period; even, >=2.

Ports:
- clk  in  1  audio clock, 24.576 MHz.
- rst_n  in  1  synchronous reset, active low.
- sample_l  in  SAMPLE_W  left sample.
- sample_r  in  SAMPLE_W  right sample.
- sample_valid  in  1  sample pair present.
- sample_ready  out  1  holding register empty; pair accepted when valid&&ready.
- bclk  out  1  bit clock.
- lrck  out  1  word select; 0 = left, 1 = right.
- sdata  out  1  serial data.
- frame_start  out  1  1-clk pulse when a new pair is loaded into the shifter.
- underrun  out  1  1-clk pulse when the frame-boundary load finds the holding register empty.

Behaviour:
- One clock, clk. Reset is synchronous, active low (rst_n); all state is sampled on rising clk.
- Reset values:
  - div_cnt=0, bit index b=0.
  - bclk=0, lrck=0, sdata=0, frame_start=0, underrun=0, sample_ready=0.
  - Holding register empty; shifter and last-pair registers 0.
  - sample_ready rises in the first clk after rst_n goes high.
- Divider:
  - div_cnt counts 0..BCLK_DIV-1 and wraps.
  - bclk is registered: 0 while div_cnt < BCLK_DIV/2, 1 otherwise.
  - The BCLK falling edge coincides with the div_cnt wrap to 0.
- Bit index:
  - b (0..2*SLOT_W-1) increments when div_cnt==BCLK_DIV-1 and wraps to 0 after 2*SLOT_W-1.
  - lrck and sdata update only at the div_cnt wrap, so they change on the BCLK falling edge and are stable at the rising edge.
- lrck:
  - lrck = ((b+1) mod 2*SLOT_W) >= SLOT_W, i.e. it leads the data by one bit (Philips I2S).
  - lrck falls at b=2*SLOT_W-1 and rises at b=SLOT_W-1.
- sdata:
  - b in 0..SAMPLE_W-1: left bit SAMPLE_W-1-b.
  - b in SLOT_W..SLOT_W+SAMPLE_W-1: right bit SAMPLE_W-1-(b-SLOT_W).
  - All other slot bits: 0.
- Load:
  - Occurs in the cycle where b==2*SLOT_W-1 and div_cnt==BCLK_DIV-1.
  - If the holding register is full: shifter <= holding, last <= holding, holding emptied, frame_start=1 for 1 clk.
  - If it is empty: shifter <= last (repeat previous pair), underrun=1 for 1 clk, and frame_start still pulses.
- Handshake:
  - sample_ready is a registered copy of !holding_full.
  - On accept, holding is captured and ready drops in the next clk.
  - Ready rises the clk after a load empties the holding register.
  - sample_valid is ignored while ready=0; there is no combinational path from valid to ready.
- Simultaneous accept and load (holding empty):
  - The frame takes the underrun path.
  - The accepted pair lands in holding and is used at the next frame.
  - No bypass.
- Latency:
  - An accepted pair appears on sdata starting at the first b=0 after the next load.
  - The left MSB is driven on the BCLK falling edge following the load.
- Reset mid-frame aborts immediately:
  - All outputs return to their reset values in the next clk.
  - The pending held pair is discarded.
  - The first frame after reset sends zeros with underrun=1 unless a pair is accepted before the first load.

Optional Feature:
- I2S_UNDERRUN_MUTE_EN
  - Defined: on underrun the shifter and last register load zeros (silence); the pulse is unchanged.
  - Undefined: repeat the last pair, as above.

Test Plan:
- Reset release, defaults, no samples:
  - bclk period is 8 clk with 50% duty; lrck period is 512 clk and toggles every 256 clk.
  - lrck edges align to the bclk falling edge.
  - underrun pulses once per 512 clk; sdata stays 0.
- Send L=16'hA5F0, R=16'h0F5A once:
  - The next frame's left slot bits 0..15 are 1010010111110000 and right slot bits 0..15 are 0000111101011010.
  - Bits 16..31 of each slot are 0.
  - frame_start pulses; underrun stays 0 for that frame.
- Back-pressure with valid held high:
  - First pair accepted, ready=0 until the load, then ready=1 exactly 1 clk after frame_start.
  - Exactly one pair is accepted per frame.
- Skip a frame after L=16'h7FFF, R=16'h8000:
  - Without macro: that pair repeats and underrun=1.
  - With I2S_UNDERRUN_MUTE_EN: the slot is all zeros and underrun=1.
- Accept in the load cycle:
  - The frame takes the underrun path.
  - The pair is output in the following frame; ready=0 in between.
- Assert rst_n=0 at b=40, mid right slot:
  - Next clk: bclk=lrck=sdata=0 and ready=0.
  - After release: timing restarts at b=0 and the held pair is lost.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// i2s_audio_tx: Philips I2S serializer with valid/ready sample intake; define I2S_UNDERRUN_MUTE_EN to send silence on underrun
module i2s_audio_tx #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W = 32,
  parameter int BCLK_DIV = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  output logic                bclk,
  output logic                lrck,
  output logic                sdata,
  output logic                frame_start,
  output logic                underrun
);
  localparam int FW = 2 * SLOT_W;
  localparam int DW = $clog2(BCLK_DIV);
  localparam int BW = $clog2(FW);
  localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
  localparam logic [BW-1:0] B_LAST = BW'(FW - 1);
  localparam logic [BW-1:0] B_SLOT = BW'(SLOT_W);
  logic [DW-1:0] div_cnt, div_nx;
  logic [BW-1:0] b, b_nx, b_la;
  logic [2*SAMPLE_W-1:0] hold, last, load_pair;
  logic [SLOT_W-1:0] slot_l, slot_r;
  logic [FW-1:0] sh, load_frame;
  logic hold_full, wrap, load, accept;
  always_comb begin
    wrap = div_cnt == DIV_LAST;
    div_nx = wrap ? '0 : div_cnt + 1'b1;
    b_nx = (b == B_LAST) ? '0 : b + 1'b1;
    b_la = (b_nx == B_LAST) ? '0 : b_nx + 1'b1;
    load = wrap && (b == B_LAST);
    accept = sample_valid && sample_ready;
`ifdef I2S_UNDERRUN_MUTE_EN
    load_pair = hold_full ? hold : '0;
`else
    load_pair = hold_full ? hold : last;
`endif
    slot_l = SLOT_W'(load_pair[2*SAMPLE_W-1:SAMPLE_W]) << (SLOT_W - SAMPLE_W);
    slot_r = SLOT_W'(load_pair[SAMPLE_W-1:0]) << (SLOT_W - SAMPLE_W);
    load_frame = {slot_l, slot_r};
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      b <= '0;
      bclk <= 1'b0;
      lrck <= 1'b0;
      sdata <= 1'b0;
      frame_start <= 1'b0;
      underrun <= 1'b0;
      sample_ready <= 1'b0;
      hold_full <= 1'b0;
      hold <= '0;
      last <= '0;
      sh <= '0;
    end else begin
      div_cnt <= div_nx;
      bclk <= div_nx >= DIV_HALF;
      if (wrap) begin
        b <= b_nx;
        lrck <= b_la >= B_SLOT;
        sdata <= load ? load_frame[FW-1] : sh[FW-1];
        sh <= load ? load_frame << 1 : sh << 1;
      end
      frame_start <= load;
      underrun <= load && !hold_full;
      if (load) last <= load_pair;
      if (accept) hold <= {sample_l, sample_r};
      hold_full <= accept || (hold_full && !load);
      sample_ready <= !accept && !hold_full;
    end
  end
endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb_i2s_audio_tx: scoreboard bench for i2s_audio_tx
module tb_i2s_audio_tx;
  typedef struct {
    logic [31:0] pair;
    int stamp;
  } acc_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] sample_l = '0;
  logic [15:0] sample_r = '0;
  logic sample_valid = 1'b0;
  logic sample_ready, bclk, lrck, sdata, frame_start, underrun;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int frames_done = 0;
  int bit_cnt = 0;
  int lr_cyc = -1;
  acc_t acc_q[$];
  logic [63:0] exp_q[$];
  logic [31:0] last = '0;
  logic [63:0] got_d = '0;
  logic [63:0] got_lr = '0;
  logic capturing = 1'b0;
  logic bclk_q = 1'b0;
  logic lr_q = 1'b0;

  i2s_audio_tx dut (
    .clk(clk), .rst_n(rst_n), .sample_l(sample_l), .sample_r(sample_r),
    .sample_valid(sample_valid), .sample_ready(sample_ready), .bclk(bclk),
    .lrck(lrck), .sdata(sdata), .frame_start(frame_start), .underrun(underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expectations come from pairs the bench saw accepted strictly before each load edge
  always @(negedge clk) begin : mon
    logic [31:0] p;
    acc_t a;
    if (!rst_n) begin
      acc_q.delete();
      exp_q.delete();
      last = '0;
      capturing = 1'b0;
      bit_cnt = 0;
      lr_cyc = -1;
      bclk_q = 1'b0;
      lr_q = 1'b0;
    end else begin
      if (frame_start) begin
        if (capturing) check("frame_len", 64'(bit_cnt), 64'd64);
        if (acc_q.size() > 0 && acc_q[0].stamp < cyc) begin
          a = acc_q.pop_front();
          p = a.pair;
          check("underrun_low", 64'(underrun), 64'd0);
        end else begin
`ifdef I2S_UNDERRUN_MUTE_EN
          p = '0;
`else
          p = last;
`endif
          check("underrun_high", 64'(underrun), 64'd1);
        end
        last = p;
        exp_q.push_back({p[31:16], 16'h0, p[15:0], 16'h0});
        capturing = 1'b1;
        bit_cnt = 0;
      end
      if (bclk && !bclk_q && capturing && bit_cnt < 64) begin
        got_d[63-bit_cnt] = sdata;
        got_lr[63-bit_cnt] = lrck;
        bit_cnt++;
        if (bit_cnt == 64) begin
          check("frame_data", got_d, exp_q.pop_front());
          check("frame_lrck", got_lr, 64'h0000_0001_FFFF_FFFE);
          frames_done++;
        end
      end
      if (lrck != lr_q) begin
        check("lrck_on_bclk_fall", 64'({bclk_q, bclk}), 64'b10);
        if (lr_cyc >= 0) check("lrck_half_period", 64'(cyc - lr_cyc), 64'd256);
        lr_cyc = cyc;
      end
      if (sample_valid && sample_ready) begin
        a.pair = {sample_l, sample_r};
        a.stamp = cyc + 1;
        acc_q.push_back(a);
      end
      bclk_q = bclk;
      lr_q = lrck;
    end
  end

  task automatic wait_fs(output int c);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 2000);
    check("frame_start_seen", 64'(frame_start), 64'd1);
    c = cyc;
  endtask

  task automatic wait_frames(input int k);
    int target, n;
    target = frames_done + k;
    n = 0;
    while (frames_done < target && n < 600 * k + 600) begin
      @(negedge clk);
      n++;
    end
    check("frames_seen", 64'(frames_done >= target), 64'd1);
  endtask

  task automatic send(input logic [31:0] p);
    int n;
    n = 0;
    {sample_l, sample_r} = p;
    sample_valid = 1'b1;
    @(negedge clk);
    while (!sample_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", 64'(sample_ready), 64'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    @(negedge clk);
    check("ready_drop", 64'(sample_ready), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1);
  end

  initial begin
    int c, r0, hi, lo, n;
    int st[4];
    logic [31:0] bp[4];
    bp[0] = 32'h1111_EEEE;
    bp[1] = 32'h2222_DDDD;
    bp[2] = 32'h3333_CCCC;
    bp[3] = 32'h4444_BBBB;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outputs", 64'({bclk, lrck, sdata, frame_start, underrun, sample_ready}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = cyc;
    @(negedge clk);
    check("ready_before_release_edge", 64'(sample_ready), 64'd0);
    @(negedge clk);
    check("ready_after_release", 64'(sample_ready), 64'd1);
    n = 0;
    while (!bclk && n < 20) begin
      @(negedge clk);
      n++;
    end
    hi = 0;
    while (bclk && hi < 20) begin
      hi++;
      @(negedge clk);
    end
    lo = 0;
    while (!bclk && lo < 20) begin
      lo++;
      @(negedge clk);
    end
    check("bclk_high", 64'(hi), 64'd4);
    check("bclk_low", 64'(lo), 64'd4);
    wait_fs(c);
    check("first_load_time", 64'(c - r0), 64'd512);
    wait_frames(2);

    send(32'hA5F0_0F5A);
    wait_frames(3);

    wait_fs(c);
    @(posedge clk);
    #1;
    {sample_l, sample_r} = bp[0];
    sample_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!sample_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("bp_first_ready", 64'(sample_ready), 64'd1);
    st[0] = cyc + 1;
    @(posedge clk);
    #1;
    for (int k = 1; k < 4; k++) begin
      {sample_l, sample_r} = bp[k];
      wait_fs(c);
      check("bp_ready_at_load", 64'(sample_ready), 64'd0);
      @(negedge clk);
      check("bp_ready_after_load", 64'(sample_ready), 64'd1);
      st[k] = cyc + 1;
      @(posedge clk);
      #1;
      if (k >= 2) check("bp_one_per_frame", 64'(st[k] - st[k-1]), 64'd512);
    end
    sample_valid = 1'b0;
    wait_frames(4);

    send(32'h7FFF_8000);
    wait_frames(4);

    wait_fs(c);
    repeat (511) @(posedge clk);
    #1;
    {sample_l, sample_r} = 32'h1234_ABCD;
    sample_valid = 1'b1;
    @(negedge clk);
    check("la_ready", 64'(sample_ready), 64'd1);
    @(posedge clk);
    #1;
    sample_valid = 1'b0;
    @(negedge clk);
    check("la_frame_start", 64'(frame_start), 64'd1);
    check("la_ready_low", 64'(sample_ready), 64'd0);
    repeat (200) @(negedge clk);
    check("la_ready_held_low", 64'(sample_ready), 64'd0);
    wait_fs(c);
    @(negedge clk);
    check("la_ready_back", 64'(sample_ready), 64'd1);
    wait_frames(2);

    wait_fs(c);
    @(posedge clk);
    #1;
    send(32'h5555_AAAA);
    @(negedge clk);
    repeat (c + 324 - cyc) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("pre_reset_b40", 64'({bclk, lrck, sdata, sample_ready}), 64'b1110);
    @(negedge clk);
    check("mid_reset_outputs", 64'({bclk, lrck, sdata, sample_ready, frame_start, underrun}), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    r0 = cyc;
    wait_fs(c);
    check("restart_load_time", 64'(c - r0), 64'd512);
    wait_frames(1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
